// File: rtl/delay_ctrl_pkg.sv
// Shared types and helpers for the delay scheduler: FSM state encoding,
// drop-counter ceiling and request clamping.
package delay_ctrl_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} dly_state_t;

  localparam logic [7:0] DROP_MAX = 8'd255;

  // Requests outside 1..max_dly are pulled to the nearest legal delay.
  function automatic int unsigned clamp_dly(input int unsigned req,
                                            input int unsigned max_dly);
    int unsigned res;
    res = req;
    if (req == 0)            res = 1;
    else if (req > max_dly)  res = max_dly;
    return res;
  endfunction

endpackage

// File: rtl/delay_sched_ctrl_inertial.sv
// Inertial filter: output follows din only after din has differed from it for
// dly consecutive cycles; shorter excursions are swallowed and counted.
module inertial_filter
  import delay_ctrl_pkg::*;
#(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din,
  input  logic [DW-1:0] dly,
  input  logic          clr,
  output logic          so_inertial,
  output logic [7:0]    drop_cnt
);

  logic [DW-1:0] icnt_q, icnt_d;
  logic          so_q, so_d;
  logic [7:0]    drop_q, drop_d;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    icnt_d = icnt_q;
    so_d   = so_q;
    drop_d = drop_q;
    if (clr) begin
      icnt_d = '0;
    end else if (din == so_q) begin
      if (icnt_q != '0 && drop_q != DROP_MAX) drop_d = drop_q + 8'd1;
      icnt_d = '0;
    end else if (icnt_q == dly - DW'(1)) begin
      so_d   = din;
      icnt_d = '0;
    end else begin
      icnt_d = icnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: flops use non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      icnt_q <= '0;
      so_q   <= 1'b0;
      drop_q <= '0;
    end else begin
      icnt_q <= icnt_d;
      so_q   <= so_d;
      drop_q <= drop_d;
    end
  end

  assign so_inertial = so_q;
  assign drop_cnt    = drop_q;

endmodule

// File: rtl/delay_sched_ctrl.sv
// Dual-path programmable delay line (transport + inertial) with a config FSM
// that only retunes the transport tap once the line has drained.
module delay_sched_ctrl
  import delay_ctrl_pkg::*;
#(
  parameter int MAX_DLY = 16,
  parameter int RST_DLY = 4,
  parameter int DW      = $clog2(MAX_DLY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din,
  input  logic          cfg_valid,
  input  logic [DW-1:0] cfg_dly,
  output logic          cfg_ready,
  output logic          so_transport,
  output logic          so_inertial,
  output logic          busy,
  output logic          cfg_err,
  output logic [7:0]    drop_cnt
);

  localparam int            IW       = $clog2(MAX_DLY);
  localparam int            TW       = $clog2(2 * MAX_DLY);
  localparam logic [TW-1:0] TMO_LAST = TW'(2 * MAX_DLY - 1);
  localparam logic [DW-1:0] DLY_RST  = DW'(RST_DLY);

  dly_state_t         state_q, state_d;
  logic [MAX_DLY-1:0] sh_q, sh_d;
  logic [DW-1:0]      dly_q, dly_d;
  logic [DW-1:0]      pend_q, pend_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               err_q, err_d;
  logic               rdy_q, rdy_d;
  logic               quiet;
  logic               take_req;
  logic               load;
  logic [IW-1:0]      tap_idx;

  assign sh_d     = {sh_q[MAX_DLY-2:0], din};
  assign quiet    = (sh_q == {MAX_DLY{din}});
  assign tap_idx  = IW'(dly_q - DW'(1));
  // The acknowledge cycle still sees cfg_valid high, so it must not start a new request.
  assign take_req = cfg_valid && !rdy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (take_req) state_d = DRAIN;
      DRAIN:   if (quiet || tmo_q == TMO_LAST) state_d = LOAD;
      LOAD:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    busy = (state_q != RUN);
    load = (state_q == LOAD);
  end

  always_comb begin
    pend_d = pend_q;
    tmo_d  = tmo_q;
    err_d  = err_q;
    dly_d  = dly_q;
    rdy_d  = 1'b0;
    case (state_q)
      RUN: begin
        tmo_d = '0;
        if (take_req) pend_d = DW'(clamp_dly(32'(cfg_dly), 32'(MAX_DLY)));
      end
      DRAIN: begin
        if (!quiet && tmo_q == TMO_LAST) err_d = 1'b1;
        tmo_d = tmo_q + TW'(1);
      end
      LOAD: begin
        dly_d = pend_q;
        rdy_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the shift register is reset too; the drain check compares its full contents against din.
    if (rst) begin
      sh_q   <= '0;
      dly_q  <= DLY_RST;
      pend_q <= DLY_RST;
      tmo_q  <= '0;
      err_q  <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      dly_q  <= dly_d;
      pend_q <= pend_d;
      tmo_q  <= tmo_d;
      err_q  <= err_d;
      rdy_q  <= rdy_d;
    end
  end

  assign so_transport = sh_q[tap_idx];
  assign cfg_ready    = rdy_q;
  assign cfg_err      = err_q;

  inertial_filter #(.DW(DW)) u_inertial (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .dly         (dly_q),
    .clr         (load),
    .so_inertial (so_inertial),
    .drop_cnt    (drop_cnt)
  );

endmodule
